// File: rtl/imem_loader.sv
// Byte-serial instruction-memory writer: takes 32-bit words over valid/ready and
// writes them little-endian, one byte per cycle, into the byte-addressed store.
module imem_loader #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [7:0]  word_count,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

    state_t      state;
    logic [31:0] word;
    logic [31:0] cur_addr;
    logic [7:0]  remaining;
    logic [1:0]  byte_idx;
    logic [33:0] req_end;
    logic        req_bad;
    logic [31:0] word_shift;

    // 34-bit end address so a huge base plus count cannot wrap into range.
    always_comb begin
        req_end    = {2'b00, base_addr} + {24'd0, word_count, 2'b00};
        req_bad    = (base_addr[1:0] != 2'b00) || (req_end > 34'(MEM_BYTES));
        word_shift = word >> {byte_idx, 3'b000};
    end

    // Outputs are registered one step ahead of the state they describe, so
    // cur_addr and byte_idx point at the next byte to put on the port and a
    // wrapped byte_idx of 0 in WRITE means all four bytes have been issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word      <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (req_bad) begin
                            err <= 1'b1;
                        end else if (word_count == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            cur_addr  <= base_addr;
                            remaining <= word_count;
                            state     <= WAIT;
                            in_ready  <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (in_valid) begin
                        word      <= in_data;
                        byte_idx  <= 2'd1;
                        in_ready  <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= cur_addr;
                        mem_wdata <= in_data[7:0];
                        cur_addr  <= cur_addr + 32'd1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (byte_idx != 2'd0) begin
                        mem_addr  <= cur_addr;
                        mem_wdata <= word_shift[7:0];
                        cur_addr  <= cur_addr + 32'd1;
                        byte_idx  <= byte_idx + 2'd1;
                    end else begin
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= WAIT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial writer for the instruction memory. Accepts a block of 32-bit instruction words over a valid/ready stream and writes each word into the byte-addressed instruction store, little-endian (byte 0 at the lowest address), one byte per cycle. It sits between a program source (testbench, boot ROM or host link) and the instruction memory's byte write port, and is the write-side counterpart of the fetch read path.

## Interface
Parameters:
- MEM_BYTES, 128: instruction store size in bytes; the legal byte addresses are 0..MEM_BYTES-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  32  first byte address of the block; sampled with start.
- word_count  input  8  number of words to load; sampled with start.
- in_data  input  32  instruction word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the loader accepts a word this cycle.
- mem_we  output  1  byte write strobe.
- mem_addr  output  32  byte address of the write.
- mem_wdata  output  8  byte to write.
- busy  output  1  a load is in progress (WAIT or WRITE state).
- done  output  1  one-cycle pulse when a load completes.
- err  output  1  one-cycle pulse when a start request is rejected.

## Operation
- **State machine:** IDLE, WAIT, WRITE, DONE.
- **Output decode:** all outputs come from registered state only. There is no combinational path from any input to any output.
- **IDLE:**
  - All outputs are 0.
  - On start, the block checks the request. It is rejected if base_addr[1:0] != 0, or if base_addr + 4*word_count > MEM_BYTES. The bound is computed in at least 34 bits, so it cannot wrap.
  - A rejected request gives an err pulse on the next cycle. The block stays in IDLE and performs no writes.
  - A legal request with word_count == 0 goes to DONE, with no writes.
  - A legal request with word_count > 0 latches cur_addr = base_addr and remaining = word_count, then goes to WAIT.
- **WAIT:**
  - in_ready = 1 and busy = 1.
  - When in_valid && in_ready, the block latches in_data into the word register, sets byte_idx = 0 and goes to WRITE.
- **WRITE:**
  - busy = 1, in_ready = 0, mem_we = 1.
  - mem_addr = cur_addr.
  - mem_wdata = word[8*byte_idx+7 : 8*byte_idx].
  - Each cycle, cur_addr and byte_idx both increment by 1.
  - After byte_idx 3, remaining decrements. If the result is 0, go to DONE; otherwise go back to WAIT.
- **DONE:**
  - done = 1 for exactly one cycle, then go to IDLE.
- **start outside IDLE:** ignored. It does not restart or extend the current load.
- **in_valid outside WAIT:** ignored. The word is not consumed, because in_ready = 0.
- **rst:** wins over every other input in every state.
  - Next state is IDLE; all outputs are 0; all counters and the word register are cleared.
  - A word that was only partly written stays partly written in memory. No write occurs on or after the reset cycle.

## Timing
- **Reset values:** in_ready, mem_we, mem_addr, mem_wdata, busy, done and err are all 0.
- **Load start:** start is sampled at edge 0. busy and in_ready go high in cycle 1.
- **Word write:** a word accepted at edge k produces writes in cycles k+1 .. k+4, at addresses A, A+1, A+2, A+3.
  - A following word can be accepted at edge k+5 at the earliest.
  - Peak throughput is 1 word per 5 cycles.
- **Completion:** done is high in the cycle after the last write, and busy is low in that cycle. A new start is accepted in the cycle after done.
- **Rejected request:** err is high in cycle 1 and busy stays low.
- **Zero-length load:** done is high in cycle 1.
- **Stalls:** in_valid low in WAIT stalls the block indefinitely. There is no timeout.

## Test plan
- **Single word:** reset, then start with base_addr = 4, word_count = 1, in_data = 0x34020026, in_valid held high.
  - Expect writes 0x26 to address 4, 0x00 to 5, 0x02 to 6 and 0x34 to 7, in four consecutive cycles.
  - Then a done pulse; in_ready is high for exactly one cycle.
- **Five-word block:** base_addr = 0, words 0x34020026, 0x34030034, 0x00628020, 0xae020001, 0x8e030001, with in_valid toggled randomly.
  - Expect 20 writes to addresses 0..19 with the correct little-endian bytes.
  - done arrives once, after the last write. No word is dropped or duplicated.
- **Rejected requests:**
  - start with base_addr = 2 gives err 1 cycle later, with no mem_we and busy = 0.
  - start with base_addr = 124, word_count = 2 gives err.
  - start with base_addr = 124, word_count = 1 is accepted.
- **Zero-length load:** word_count = 0 gives done in cycle 1, no writes, and in_ready never high.
- **Ignored inputs:** a second start asserted during WRITE is ignored; the load continues and ends with exactly one done. in_valid held high in DONE/IDLE does not cause a write.
- **Reset mid-load:** assert rst during the write of byte 2 of a word.
  - Next cycle: all outputs are 0 and the state is IDLE.
  - Address A+3 is not written.
  - A fresh start then runs normally.
